// File: rtl/ib_lut_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ib_lut_pkg : loader FSM states and page-geometry helpers for the CN IB-LUT
// Rev 1.0
// ---------------------------------------------------------------------------
package ib_lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_B0 = 2'd1,
    GET_B1 = 2'd2,
    DONE   = 2'd3
  } lut_state_e;

  function automatic int calc_page_aw(input int entry_addr, input int frame_num);
    return entry_addr - $clog2(frame_num);
  endfunction

  function automatic int calc_page_num(input int entry_addr, input int frame_num);
    return 1 << calc_page_aw(entry_addr, frame_num);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sym_cn_lut_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sym_cn_lut_loader : packs a LUT entry stream into bank0/bank1 page writes and
// ping-pongs the active read region on completion.  Rev 1.0
// ---------------------------------------------------------------------------
module sym_cn_lut_loader
  import ib_lut_pkg::*;
#(
  parameter int QUAN_SIZE       = 3,
  parameter int LUT_PORT_SIZE   = 2,
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     load_start,
  output logic                     load_busy,
  output logic                     load_done,
  input  logic [LUT_PORT_SIZE-1:0] lut_data,
  input  logic                     lut_valid,
  output logic                     lut_ready,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
  output logic [calc_page_aw(ENTRY_ADDR, MULTI_FRAME_NUM)-1:0] page_write_addr,
  output logic                     write_addr_offset,
  output logic                     we,
  output logic                     read_addr_offset
);

  localparam int PAGE_AW = calc_page_aw(ENTRY_ADDR, MULTI_FRAME_NUM);
  localparam logic [PAGE_AW-1:0] LAST_PAGE = '1;

  // Offsets are single-bit inversions, so only a two-region ping-pong is legal.
  if (MULTI_FRAME_NUM != 2 || QUAN_SIZE < 1) begin : g_bad_cfg
    $error("sym_cn_lut_loader supports MULTI_FRAME_NUM == 2 only");
  end

  lut_state_e               state, state_nxt;
  logic [PAGE_AW-1:0]       page_cnt, page_cnt_nxt;
  logic [LUT_PORT_SIZE-1:0] held, held_nxt;
  logic [LUT_PORT_SIZE-1:0] bank0_nxt, bank1_nxt;
  logic [PAGE_AW-1:0]       page_addr_nxt;
  logic                     busy_nxt, done_nxt, we_nxt, ready_nxt;
  logic                     wr_off_nxt, rd_off_nxt;
  logic                     handshake;

  assign handshake = lut_valid & lut_ready;

  always_comb begin
    state_nxt     = state;
    page_cnt_nxt  = page_cnt;
    held_nxt      = held;
    bank0_nxt     = lut_in_bank0;
    bank1_nxt     = lut_in_bank1;
    page_addr_nxt = page_write_addr;
    busy_nxt      = load_busy;
    done_nxt      = 1'b0;
    we_nxt        = 1'b0;
    wr_off_nxt    = write_addr_offset;
    rd_off_nxt    = read_addr_offset;
    case (state)
      IDLE: begin
        if (load_start) begin
          wr_off_nxt   = ~read_addr_offset;
          page_cnt_nxt = '0;
          busy_nxt     = 1'b1;
          state_nxt    = GET_B0;
        end
      end
      GET_B0: begin
        if (handshake) begin
          held_nxt  = lut_data;
          state_nxt = GET_B1;
        end
      end
      GET_B1: begin
        if (handshake) begin
          we_nxt        = 1'b1;
          bank0_nxt     = held;
          bank1_nxt     = lut_data;
          page_addr_nxt = page_cnt;
          if (page_cnt == LAST_PAGE) begin
            state_nxt = DONE;
          end else begin
            page_cnt_nxt = page_cnt + PAGE_AW'(1);
            state_nxt    = GET_B0;
          end
        end
      end
      DONE: begin
        done_nxt   = 1'b1;
        rd_off_nxt = write_addr_offset;
        busy_nxt   = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Ready is registered, so it is derived from where the FSM is heading.
    ready_nxt = (state_nxt == GET_B0) || (state_nxt == GET_B1);
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      state             <= IDLE;
      page_cnt          <= '0;
      held              <= '0;
      lut_in_bank0      <= '0;
      lut_in_bank1      <= '0;
      page_write_addr   <= '0;
      load_busy         <= 1'b0;
      load_done         <= 1'b0;
      we                <= 1'b0;
      lut_ready         <= 1'b0;
      write_addr_offset <= 1'b1;
      read_addr_offset  <= 1'b0;
    end else begin
      state             <= state_nxt;
      page_cnt          <= page_cnt_nxt;
      held              <= held_nxt;
      lut_in_bank0      <= bank0_nxt;
      lut_in_bank1      <= bank1_nxt;
      page_write_addr   <= page_addr_nxt;
      load_busy         <= busy_nxt;
      load_done         <= done_nxt;
      we                <= we_nxt;
      lut_ready         <= ready_nxt;
      write_addr_offset <= wr_off_nxt;
      read_addr_offset  <= rd_off_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sym_cn_lut_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sym_cn_lut_loader : directed bench with a transaction-level loader model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sym_cn_lut_loader;

  localparam int PN = 8;
  localparam int NENT = 2 * PN;

  logic       clk = 1'b0;
  logic       rstn, load_start, load_busy, load_done;
  logic [1:0] lut_data, bank0, bank1;
  logic       lut_valid, lut_ready, we, wr_off, rd_off;
  logic [2:0] page;

  always #5 clk = ~clk;

  sym_cn_lut_loader #(
    .QUAN_SIZE(3), .LUT_PORT_SIZE(2), .ENTRY_ADDR(4), .MULTI_FRAME_NUM(2)
  ) dut (
    .write_clk(clk), .rstn(rstn), .load_start(load_start), .load_busy(load_busy),
    .load_done(load_done), .lut_data(lut_data), .lut_valid(lut_valid),
    .lut_ready(lut_ready), .lut_in_bank0(bank0), .lut_in_bank1(bank1),
    .page_write_addr(page), .write_addr_offset(wr_off), .we(we),
    .read_addr_offset(rd_off)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream table and stimulus controls (owned by the main process).
  logic [1:0] tbl [NENT];
  bit stream_en = 1'b0;
  bit gaps      = 1'b0;

  // Transaction-level model: counts entries consumed in the current load and
  // derives every output from that count.
  bit         started = 1'b0;
  bit         m_busy, m_rd, m_wr, m_we, m_done, m_ready, m_hs;
  int         m_cnt;
  logic [1:0] m_held, m_b0, m_b1;
  logic [2:0] m_page;

  always @(posedge clk) begin
    m_hs   = 1'b0;
    m_we   = 1'b0;
    m_done = 1'b0;
    if (!rstn) begin
      m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b1; m_cnt = 0;
      m_held = '0; m_b0 = '0; m_b1 = '0; m_page = '0;
    end else if (m_busy && m_cnt == NENT) begin
      m_done = 1'b1;
      m_rd   = m_wr;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (lut_valid && m_ready) begin
        m_hs = 1'b1;
        if (m_cnt % 2 == 0) begin
          m_held = lut_data;
        end else begin
          m_we   = 1'b1;
          m_b0   = m_held;
          m_b1   = lut_data;
          m_page = 3'(m_cnt / 2);
        end
        m_cnt++;
      end
    end else if (load_start) begin
      m_busy = 1'b1;
      m_wr   = ~m_rd;
      m_cnt  = 0;
    end
    m_ready = m_busy && (m_cnt < NENT);
    started = 1'b1;
  end

  // Stream source: presents the entry the model will consume next.
  always @(negedge clk) begin
    if (stream_en) begin
      lut_data  = tbl[m_cnt % NENT];
      lut_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      lut_data  = '0;
      lut_valid = 1'b0;
    end
  end

  // Per-cycle compare against the model.
  int         n_we = 0;
  int         n_done = 0;
  logic [1:0] first_b0, first_b1;

  always @(negedge clk) begin
    if (started) begin
      chk("we", we, m_we);
      chk("page", page, m_page);
      chk("bank0", bank0, m_b0);
      chk("bank1", bank1, m_b1);
      chk("wr_off", wr_off, m_wr);
      chk("rd_off", rd_off, m_rd);
      chk("busy", load_busy, m_busy);
      chk("done", load_done, m_done);
      chk("ready", lut_ready, m_ready);
      if (we === 1'b1) begin
        n_we++;
        if (page === 3'd0) begin
          first_b0 = bank0;
          first_b1 = bank1;
        end
      end
      if (load_done === 1'b1) n_done++;
    end
  end

  task automatic run_load(input int a, input int b, input bit extra, output int cyc);
    int we0, done0;
    for (int k = 0; k < NENT; k++) tbl[k] = 2'((k * a + b) % 4);
    we0   = n_we;
    done0 = n_done;
    load_start = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      load_start = extra && (cyc == 3 || cyc == 10);
      if (load_done === 1'b1) break;
    end
    load_start = 1'b0;
    chk("load_done_seen", load_done, 1'b1);
    repeat (4) @(negedge clk);
    chk("writes_per_load", n_we - we0, PN);
    chk("dones_per_load", n_done - done0, 1);
    chk("idle_after_load", load_busy, 1'b0);
  endtask

  int cyc, we_snap, guard;

  initial begin
    rstn = 1'b0;
    load_start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_we", we, 1'b0);
    chk("rst_rd_off", rd_off, 1'b0);
    chk("rst_wr_off", wr_off, 1'b1);
    chk("rst_busy", load_busy, 1'b0);

    // Continuous stream d[k] = k%4.
    stream_en = 1'b1;
    run_load(1, 0, 1'b0, cyc);
    chk("load1_latency", cyc, 18);
    chk("load1_first_b0", first_b0, 2'd0);
    chk("load1_first_b1", first_b1, 2'd1);
    chk("load1_rd_off", rd_off, 1'b1);

    // Second load lands in region 0.
    run_load(3, 1, 1'b0, cyc);
    chk("load2_latency", cyc, 18);
    chk("load2_rd_off", rd_off, 1'b0);
    chk("load2_wr_off", wr_off, 1'b0);

    // Random valid gaps.
    gaps = 1'b1;
    run_load(1, 2, 1'b0, cyc);
    gaps = 1'b0;
    chk("gap_latency_ge18", cyc >= 18, 1'b1);
    chk("load3_rd_off", rd_off, 1'b1);

    // Redundant starts mid-load.
    run_load(2, 1, 1'b1, cyc);
    chk("extra_start_latency", cyc, 18);
    chk("load4_rd_off", rd_off, 1'b0);

    // Reset right after page 4 is written.
    tbl[0] = 2'd3;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    guard = 0;
    while (!(we === 1'b1 && page === 3'd4) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("page4_reached", guard < 200, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_we", we, 1'b0);
    chk("midrst_busy", load_busy, 1'b0);
    chk("midrst_rd_off", rd_off, 1'b0);
    chk("midrst_wr_off", wr_off, 1'b1);
    chk("midrst_page", page, 3'd0);
    chk("midrst_ready", lut_ready, 1'b0);
    run_load(3, 3, 1'b0, cyc);
    chk("reload_latency", cyc, 18);
    chk("reload_first_b0", first_b0, 2'd3);
    chk("reload_first_b1", first_b1, 2'd2);
    chk("reload_rd_off", rd_off, 1'b1);

    // Stream offered while idle with no start.
    we_snap = n_we;
    repeat (10) @(negedge clk);
    chk("idle_ready", lut_ready, 1'b0);
    chk("idle_no_we", n_we - we_snap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
